spi_master_byte: RTL and testbench

Single-byte SPI mode-0 master that performs the serial transfer ordered by the SPI control FSM. The block takes a one-cycle start strobe and a byte, drives chip select, SCLK and MOSI, and samples MISO. It returns the received byte with a one-cycle `o_RX_DV` pulse. That pulse feeds the control FSM's `i_RX_DV` input, and `i_TX_DV` is driven from the FSM's `inicio` output.

---
 rtl/spi_master_byte_if.sv | 28 ++
 rtl/spi_master_byte.sv | 160 ++++++++++++++++
 tb/tb_spi_master_byte.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_byte_if.sv
// spi_master_byte_if: bundles the transfer handshake and the SPI pins of spi_master_byte.
//   i_TX_DV / i_TX_Byte      : start strobe and byte to send
//   o_TX_Ready               : block idle, strobe will be accepted
//   o_RX_DV / o_RX_Byte      : one-cycle received-byte pulse and the held received byte
//   o_SPI_Clk / o_SPI_MOSI / o_SPI_CS_n / i_SPI_MISO : SPI mode-0 pins
// Modport master is the SPI master block itself; modport slave is the surrounding
// logic that issues transfers and models the serial slave.
interface spi_master_byte_if;
  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;
  logic       o_TX_Ready;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_SPI_Clk;
  logic       o_SPI_MOSI;
  logic       o_SPI_CS_n;
  logic       i_SPI_MISO;

  modport master (
    input  i_TX_DV, i_TX_Byte, i_SPI_MISO,
    output o_TX_Ready, o_RX_DV, o_RX_Byte, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
  );

  modport slave (
    output i_TX_DV, i_TX_Byte, i_SPI_MISO,
    input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
  );
endinterface

// File: rtl/spi_master_byte.sv
// spi_master_byte: single-byte SPI mode-0 master (CPOL=0, CPHA=0, MSB first).
// A strobe on i_TX_DV while idle starts one 8-bit full-duplex transfer; the received
// byte is presented on o_RX_Byte with a one-cycle o_RX_DV pulse 18*H clocks later.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : spi_master_byte_if.master (handshake + SPI pins)
// Parameter:
//   CLKS_PER_HALF_BIT (H) : system clocks per SCLK half-period, legal range 1..255.
module spi_master_byte #(
  parameter int unsigned CLKS_PER_HALF_BIT = 2
) (
  input logic               clk,
  input logic               rst,
  spi_master_byte_if.master bus
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_HALF_BIT + 1);
  localparam logic [CntW-1:0] HalfMax = CntW'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] half_cnt_q, half_cnt_d;
  logic [4:0]      edge_cnt_q, edge_cnt_d;
  // Only bits 6..0 of the TX byte still need sending once bit 7 is on MOSI.
  logic [6:0]      tx_rest_q, tx_rest_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic            ready_q, ready_d;
  logic            rx_dv_q, rx_dv_d;

  logic            half_done;
  logic [4:0]      edge_next;
  logic            last_edge;

  assign half_done = (half_cnt_q == HalfMax);
  assign edge_next = edge_cnt_q + 5'd1;
  assign last_edge = (edge_next == 5'd16);

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      half_cnt_q <= '0;
      edge_cnt_q <= '0;
      tx_rest_q  <= '0;
      rx_sr_q    <= '0;
      rx_byte_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      ready_q    <= 1'b1;
      rx_dv_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_rest_q  <= tx_rest_d;
      rx_sr_q    <= rx_sr_d;
      rx_byte_q  <= rx_byte_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      ready_q    <= ready_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.i_TX_DV) state_d = StSetup;
      StSetup: if (half_done) state_d = StShift;
      StShift: if (half_done && last_edge) state_d = StHold;
      StHold:  if (half_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    half_cnt_d = half_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_rest_d  = tx_rest_q;
    rx_sr_d    = rx_sr_q;
    rx_byte_d  = rx_byte_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    ready_d    = ready_q;
    rx_dv_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_TX_DV) begin
          tx_rest_d  = bus.i_TX_Byte[6:0];
          mosi_d     = bus.i_TX_Byte[7];
          cs_n_d     = 1'b0;
          ready_d    = 1'b0;
          half_cnt_d = '0;
        end
      end

      StSetup: begin
        if (half_done) begin
          half_cnt_d = '0;
          edge_cnt_d = '0;
        end else begin
          half_cnt_d = half_cnt_q + CntW'(1);
        end
      end

      StShift: begin
        if (half_done) begin
          half_cnt_d = '0;
          edge_cnt_d = edge_next;
          sclk_d     = ~sclk_q;
          if (!sclk_q) begin
            // Rising edge: sample MISO, MSB arrives first
            rx_sr_d = {rx_sr_q[6:0], bus.i_SPI_MISO};
          end else if (!last_edge) begin
            // Falling edge: present the next TX bit; the final falling edge leaves MOSI alone
            mosi_d    = tx_rest_q[6];
            tx_rest_d = {tx_rest_q[5:0], 1'b0};
          end
        end else begin
          half_cnt_d = half_cnt_q + CntW'(1);
        end
      end

      StHold: begin
        if (half_done) begin
          half_cnt_d = '0;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_byte_d  = rx_sr_q;
          rx_dv_d    = 1'b1;
          ready_d    = 1'b1;
        end else begin
          half_cnt_d = half_cnt_q + CntW'(1);
        end
      end

      default: ;
    endcase
  end

  assign bus.o_SPI_Clk  = sclk_q;
  assign bus.o_SPI_MOSI = mosi_q;
  assign bus.o_SPI_CS_n = cs_n_q;
  assign bus.o_TX_Ready = ready_q;
  assign bus.o_RX_DV    = rx_dv_q;
  assign bus.o_RX_Byte  = rx_byte_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// tb_spi_master_byte: directed bench for spi_master_byte with H=2 (dut_a) and H=1 (dut_b).
module tb_spi_master_byte;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_byte_if bus_a ();
  spi_master_byte_if bus_b ();

  // MISO source: either looped back from MOSI or a constant level
  logic loop_a, miso_a, loop_b, miso_b;
  assign bus_a.i_SPI_MISO = loop_a ? bus_a.o_SPI_MOSI : miso_a;
  assign bus_b.i_SPI_MISO = loop_b ? bus_b.o_SPI_MOSI : miso_b;

  spi_master_byte #(.CLKS_PER_HALF_BIT(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  spi_master_byte #(.CLKS_PER_HALF_BIT(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  // Runs one transfer on dut_a (accept edge = cycle 0) and observes ncyc following cycles.
  // Optionally pulses i_TX_DV with inj_byte after cycle inj_cycle.
  task automatic xfer_a(input logic [7:0] tx, input int inj_cycle, input logic [7:0] inj_byte,
                        input int ncyc, output int dv_count, output int dv_cycle,
                        output logic [7:0] rx, output int toggles, output int first_tog,
                        output int last_tog, output logic [7:0] mosi_bits, output int cs_rise,
                        output logic cs_at_accept);
    logic prev_sclk;
    dv_count  = 0;
    dv_cycle  = -1;
    rx        = 8'h00;
    toggles   = 0;
    first_tog = -1;
    last_tog  = -1;
    mosi_bits = 8'h00;
    cs_rise   = -1;
    bus_a.i_TX_Byte = tx;
    bus_a.i_TX_DV   = 1'b1;
    @(posedge clk); #1;
    bus_a.i_TX_DV = 1'b0;
    cs_at_accept  = bus_a.o_SPI_CS_n;
    prev_sclk     = bus_a.o_SPI_Clk;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      bus_a.i_TX_DV = 1'b0;
      if (bus_a.o_SPI_Clk !== prev_sclk) begin
        toggles++;
        if (first_tog < 0) first_tog = n;
        last_tog = n;
        if (bus_a.o_SPI_Clk === 1'b1) mosi_bits = {mosi_bits[6:0], bus_a.o_SPI_MOSI};
      end
      prev_sclk = bus_a.o_SPI_Clk;
      if (bus_a.o_RX_DV === 1'b1) begin
        dv_count++;
        if (dv_cycle < 0) begin
          dv_cycle = n;
          rx       = bus_a.o_RX_Byte;
        end
      end
      if (cs_rise < 0 && bus_a.o_SPI_CS_n === 1'b1) cs_rise = n;
      if (n == inj_cycle) begin
        bus_a.i_TX_Byte = inj_byte;
        bus_a.i_TX_DV   = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_a.i_TX_DV = 1'b0; bus_a.i_TX_Byte = 8'h00;
    bus_b.i_TX_DV = 1'b0; bus_b.i_TX_Byte = 8'h00;
    loop_a = 1'b0; miso_a = 1'b0; loop_b = 1'b0; miso_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (bus_a.o_SPI_CS_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", bus_a.o_SPI_CS_n); end
    checks++;
    if (bus_a.o_SPI_Clk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", bus_a.o_SPI_Clk); end
    checks++;
    if (bus_a.o_SPI_MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", bus_a.o_SPI_MOSI); end
    checks++;
    if (bus_a.o_TX_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus_a.o_TX_Ready); end
    checks++;
    if (bus_a.o_RX_DV !== 1'b0) begin errors++; $display("FAIL reset_rx_dv: got %b expected 0", bus_a.o_RX_DV); end
    checks++;
    if (bus_a.o_RX_Byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte: got %h expected 00", bus_a.o_RX_Byte); end
    checks++;
    if ({bus_b.o_SPI_CS_n, bus_b.o_SPI_Clk, bus_b.o_TX_Ready, bus_b.o_RX_DV} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_b_ctrl: got %b expected 1010",
               {bus_b.o_SPI_CS_n, bus_b.o_SPI_Clk, bus_b.o_TX_Ready, bus_b.o_RX_DV});
    end
    checks++;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_loopback;
    int dv_count, dv_cycle, toggles, first_tog, last_tog, cs_rise;
    logic [7:0] rx, mosi_bits;
    logic cs0;
    loop_a = 1'b1;
    xfer_a(8'hA5, -1, 8'h00, 45, dv_count, dv_cycle, rx, toggles, first_tog, last_tog,
           mosi_bits, cs_rise, cs0);
    if (cs0 !== 1'b0) begin errors++; $display("FAIL loop_cs_accept: got %b expected 0", cs0); end
    checks++;
    if (dv_cycle != 36) begin errors++; $display("FAIL loop_dv_cycle: got %0d expected 36", dv_cycle); end
    checks++;
    if (dv_count != 1) begin errors++; $display("FAIL loop_dv_count: got %0d expected 1", dv_count); end
    checks++;
    if (rx !== 8'hA5) begin errors++; $display("FAIL loop_rx: got %h expected a5", rx); end
    checks++;
    if (toggles != 16) begin errors++; $display("FAIL loop_toggles: got %0d expected 16", toggles); end
    checks++;
    if (first_tog != 4 || last_tog != 34) begin
      errors++; $display("FAIL loop_tog_span: got %0d..%0d expected 4..34", first_tog, last_tog);
    end
    checks++;
    if (cs_rise != 36) begin errors++; $display("FAIL loop_cs_rise: got %0d expected 36", cs_rise); end
    checks++;
    if (mosi_bits !== 8'hA5) begin errors++; $display("FAIL loop_mosi: got %h expected a5", mosi_bits); end
    checks++;
    if (bus_a.o_RX_Byte !== 8'hA5) begin errors++; $display("FAIL loop_rx_hold: got %h expected a5", bus_a.o_RX_Byte); end
    checks++;
  endtask

  task automatic test_fixed_miso;
    int dv_count, dv_cycle, toggles, first_tog, last_tog, cs_rise;
    logic [7:0] rx, mosi_bits;
    logic cs0;
    loop_a = 1'b0; miso_a = 1'b1;
    xfer_a(8'h3C, -1, 8'h00, 45, dv_count, dv_cycle, rx, toggles, first_tog, last_tog,
           mosi_bits, cs_rise, cs0);
    if (rx !== 8'hFF) begin errors++; $display("FAIL fixed_rx: got %h expected ff", rx); end
    checks++;
    if (mosi_bits !== 8'h3C) begin errors++; $display("FAIL fixed_mosi: got %h expected 3c", mosi_bits); end
    checks++;
    if (bus_a.o_SPI_MOSI !== 1'b0) begin errors++; $display("FAIL fixed_mosi_idle: got %b expected 0", bus_a.o_SPI_MOSI); end
    checks++;
  endtask

  task automatic test_busy_strobe;
    int dv_count, dv_cycle, toggles, first_tog, last_tog, cs_rise;
    logic [7:0] rx, mosi_bits;
    logic cs0;
    loop_a = 1'b1;
    xfer_a(8'h81, 10, 8'h7E, 50, dv_count, dv_cycle, rx, toggles, first_tog, last_tog,
           mosi_bits, cs_rise, cs0);
    if (dv_count != 1) begin errors++; $display("FAIL busy_dv_count: got %0d expected 1", dv_count); end
    checks++;
    if (mosi_bits !== 8'h81) begin errors++; $display("FAIL busy_mosi: got %h expected 81", mosi_bits); end
    checks++;
    if (rx !== 8'h81) begin errors++; $display("FAIL busy_rx: got %h expected 81", rx); end
    checks++;
    if (bus_a.o_TX_Ready !== 1'b1) begin errors++; $display("FAIL busy_ready_end: got %b expected 1", bus_a.o_TX_Ready); end
    checks++;
  endtask

  task automatic test_back_to_back;
    int dv1, dv2, cs_high;
    logic sent2;
    logic [7:0] rx1, rx2;
    dv1 = -1; dv2 = -1; cs_high = 0; sent2 = 1'b0; rx1 = 8'h00; rx2 = 8'h00;
    loop_a = 1'b1;
    bus_a.i_TX_Byte = 8'h12;
    bus_a.i_TX_DV   = 1'b1;
    @(posedge clk); #1;
    bus_a.i_TX_DV = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      bus_a.i_TX_DV = 1'b0;
      if (bus_a.o_RX_DV === 1'b1) begin
        if (dv1 < 0) begin dv1 = n; rx1 = bus_a.o_RX_Byte; end
        else if (dv2 < 0) begin dv2 = n; rx2 = bus_a.o_RX_Byte; end
      end
      if (n < 73 && bus_a.o_SPI_CS_n === 1'b1) cs_high++;
      if (!sent2 && bus_a.o_TX_Ready === 1'b1) begin
        sent2 = 1'b1;
        bus_a.i_TX_Byte = 8'h34;
        bus_a.i_TX_DV   = 1'b1;
      end
    end
    if (dv1 != 36) begin errors++; $display("FAIL b2b_dv1: got %0d expected 36", dv1); end
    checks++;
    if (dv2 - dv1 != 37) begin errors++; $display("FAIL b2b_gap: got %0d expected 37", dv2 - dv1); end
    checks++;
    if (cs_high != 1) begin errors++; $display("FAIL b2b_cs_high: got %0d expected 1", cs_high); end
    checks++;
    if (rx1 !== 8'h12 || rx2 !== 8'h34) begin
      errors++; $display("FAIL b2b_rx: got %h,%h expected 12,34", rx1, rx2);
    end
    checks++;
  endtask

  task automatic test_reset_mid;
    int dv_seen, cs_bad;
    int dv_count, dv_cycle, toggles, first_tog, last_tog, cs_rise;
    logic [7:0] rx, mosi_bits;
    logic cs0;
    dv_seen = 0; cs_bad = 0;
    loop_a = 1'b1;
    bus_a.i_TX_Byte = 8'hF0;
    bus_a.i_TX_DV   = 1'b1;
    @(posedge clk); #1;
    bus_a.i_TX_DV = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      if (bus_a.o_RX_DV === 1'b1) dv_seen++;
    end
    if (bus_a.o_SPI_CS_n !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got cs_n %b expected 0", bus_a.o_SPI_CS_n); end
    checks++;
    rst = 1'b1;
    #1;
    // No clock edge since rst rose: outputs must already be at reset values
    if ({bus_a.o_SPI_CS_n, bus_a.o_SPI_Clk, bus_a.o_TX_Ready, bus_a.o_RX_DV, bus_a.o_SPI_MOSI} !== 5'b10100) begin
      errors++;
      $display("FAIL rstmid_async: got %b expected 10100",
               {bus_a.o_SPI_CS_n, bus_a.o_SPI_Clk, bus_a.o_TX_Ready, bus_a.o_RX_DV, bus_a.o_SPI_MOSI});
    end
    checks++;
    if (bus_a.o_RX_Byte !== 8'h00) begin errors++; $display("FAIL rstmid_rx_byte: got %h expected 00", bus_a.o_RX_Byte); end
    checks++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus_a.o_RX_DV === 1'b1) dv_seen++;
      if (bus_a.o_SPI_CS_n !== 1'b1) cs_bad++;
    end
    if (dv_seen != 0) begin errors++; $display("FAIL rstmid_no_dv: got %0d expected 0", dv_seen); end
    checks++;
    if (cs_bad != 0) begin errors++; $display("FAIL rstmid_cs_idle: got %0d low cycles expected 0", cs_bad); end
    checks++;
    xfer_a(8'h5A, -1, 8'h00, 45, dv_count, dv_cycle, rx, toggles, first_tog, last_tog,
           mosi_bits, cs_rise, cs0);
    if (dv_cycle != 36 || rx !== 8'h5A) begin
      errors++; $display("FAIL rstmid_after: got cycle %0d rx %h expected 36 5a", dv_cycle, rx);
    end
    checks++;
  endtask

  task automatic test_min_divider;
    int dv_cycle, dv_count, toggles, first_tog, last_tog;
    logic [7:0] rx;
    logic prev;
    dv_cycle = -1; dv_count = 0; toggles = 0; first_tog = -1; last_tog = -1; rx = 8'h00;
    loop_b = 1'b1;
    bus_b.i_TX_Byte = 8'hC3;
    bus_b.i_TX_DV   = 1'b1;
    @(posedge clk); #1;
    bus_b.i_TX_DV = 1'b0;
    prev = bus_b.o_SPI_Clk;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      if (bus_b.o_SPI_Clk !== prev) begin
        toggles++;
        if (first_tog < 0) first_tog = n;
        last_tog = n;
      end
      prev = bus_b.o_SPI_Clk;
      if (bus_b.o_RX_DV === 1'b1) begin
        dv_count++;
        if (dv_cycle < 0) begin dv_cycle = n; rx = bus_b.o_RX_Byte; end
      end
    end
    if (dv_cycle != 18) begin errors++; $display("FAIL h1_dv_cycle: got %0d expected 18", dv_cycle); end
    checks++;
    if (rx !== 8'hC3) begin errors++; $display("FAIL h1_rx: got %h expected c3", rx); end
    checks++;
    // 16 toggles on consecutive cycles 2..17 means a 2-cycle SCLK period
    if (toggles != 16 || first_tog != 2 || last_tog != 17) begin
      errors++;
      $display("FAIL h1_sclk: got %0d toggles %0d..%0d expected 16 toggles 2..17",
               toggles, first_tog, last_tog);
    end
    checks++;
    if (dv_count != 1) begin errors++; $display("FAIL h1_dv_count: got %0d expected 1", dv_count); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_fixed_miso();
    test_busy_strobe();
    test_back_to_back();
    test_reset_mid();
    test_min_divider();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
